// File: rtl/cmp_iter.sv
// Multi-cycle branch comparator: resolves one CHUNK-bit slice per cycle, MSB slice first, for eight compare ops.
// done/result arrive N+1 cycles after start (sooner with EARLY_EXIT); start is ignored while busy, flush aborts.
module cmp_iter #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             result
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_q, eq_d, lt_q, lt_d, result_q, result_d;

    logic [CW-1:0]    sidx;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic             differ, finish;

    function automatic logic map_res(input logic [2:0] o, input logic e, input logic l);
        case (o)
            3'b000:  map_res = e;
            3'b001:  map_res = !e;
            3'b010:  map_res = l;
            3'b011:  map_res = l;
            3'b100:  map_res = l | e;
            3'b101:  map_res = !(l | e);
            3'b110:  map_res = l;
            default: map_res = !l;
        endcase
    endfunction

    // Slice select; signed ops flip the sign bit of the top slice so an unsigned compare orders them.
    always_comb begin
        sidx = CW'(N - 1) - cnt_q;
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (sidx == CW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
        if ((cnt_q == '0) && ((op_q == 3'b010) || op_q[2])) begin
            a_sl[CHUNK-1] = ~a_sl[CHUNK-1];
            b_sl[CHUNK-1] = ~b_sl[CHUNK-1];
        end
        differ = (a_sl != b_sl);
        finish = (cnt_q == CW'(N - 1)) || ((EARLY_EXIT != 0) && eq_q && differ);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_BUSY;
                S_BUSY:  if (finish) state_d = S_DONE;
                S_DONE:  state_d = start ? S_BUSY : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_BUSY);
        done = (state_q == S_DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        result_d = result_q;
        if (!flush) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_d   = a;
                        b_d   = op[2] ? '0 : b;
                        op_d  = op;
                        cnt_d = '0;
                        eq_d  = 1'b1;
                        lt_d  = 1'b0;
                    end
                end
                S_BUSY: begin
                    // Only the first differing slice decides the ordering.
                    if (eq_q && differ) begin
                        eq_d = 1'b0;
                        lt_d = (a_sl < b_sl);
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (finish) result_d = map_res(op_q, eq_d, lt_d);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            result_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
endmodule

// File: doc/cmp_iter.md
Name: cmp_iter

Overview:
Parametrised, multi-cycle branch comparator for the D-stage branch path. It generalises the single-cycle equality compare to eight compare modes, signed and unsigned, at configurable width. It resolves one CHUNK-bit slice per cycle, MSB slice first, so the wide compare leaves the D-stage critical path. It asserts busy so the hazard unit stalls D until done.

Parameters:
WIDTH, 32, operand width in bits.
CHUNK, 8, bits compared per cycle; WIDTH must be an integer multiple of CHUNK; N = WIDTH/CHUNK.
EARLY_EXIT, 0, 1 = finish as soon as the first differing slice is found.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
flush  input  1  abort current operation (pipeline flush).
op  input  3  000 EQ, 001 NE, 010 LT signed, 011 LT unsigned, 100 LEZ, 101 GTZ, 110 LTZ, 111 GEZ.
a  input  WIDTH  operand A, latched on start.
b  input  WIDTH  operand B, latched on start; ignored (forced to 0) for ops 1xx.
busy  output  1  high while in BUSY.
done  output  1  one-cycle pulse: result valid.
result  output  1  branch condition; held from done until the next accepted start.

Behaviour:
- Reset (sync, active-high) forces state IDLE, busy=0, done=0, result=0, slice counter=0, latched operands=0. Reset wins over start and flush in the same cycle.
- Reset mid-operation discards the operation; no done follows.
- States:
  - IDLE: start=1 latches a, b, op (b=0 for ops 1xx), counter=0, goes to BUSY.
  - BUSY: each cycle compares slice index N-1-counter, then counter+1.
  - BUSY exits to DONE after slice 0 is compared.
  - With EARLY_EXIT=1, BUSY also exits to DONE on the first slice that differs.
  - DONE: done=1 for exactly one cycle. start=1 in DONE is accepted (back-to-back, next state BUSY); otherwise next state is IDLE.
- Comparison, carried across slices:
  - eq_so_far starts at 1.
  - The first differing slice fixes lt and clears eq_so_far; later slices do not change either.
  - In that slice, lt = (slice of a < slice of b), unsigned.
  - Signed ops (010, 1xx): in the top slice, invert the MSB of both operands before comparing.
- Result mapping:
  - EQ = eq.
  - NE = !eq.
  - LT signed and LT unsigned = lt.
  - LEZ = lt | eq.
  - GTZ = !(lt | eq).
  - LTZ = lt.
  - GEZ = !lt.
- Latency (cycle 0 = cycle start is sampled):
  - busy is high in cycles 1..N; done and new result appear in cycle N+1.
  - With EARLY_EXIT, a first difference at slice position i (0 = top slice) gives done in cycle i+2.
  - Equal operands always take N+1 cycles.
- start during BUSY is ignored; no queueing.
- flush=1 in any state returns to IDLE next cycle with busy=0 and done=0. result keeps its previous value.
- flush and start in the same cycle: flush wins and start is dropped.
- busy and done are never high in the same cycle.
- result changes only on the DONE transition or on reset.

Test Plan:
- WIDTH=32, CHUNK=8, op=EQ, a=b=0x12345678, start at cycle 0 -> busy high in cycles 1-4, done=1 in cycle 5, result=1; op=NE with same operands -> result=0.
- op=LT signed, a=0xFFFFFFFF, b=0x00000001 -> result=1; op=LT unsigned, same operands -> result=0; with EARLY_EXIT=1, done in cycle 2.
- Zero compares, b driven 0xDEADBEEF (must be ignored): GEZ a=0x80000000 -> 0; LEZ a=0 -> 1; GTZ a=0x00000001 -> 1; LTZ a=0x7FFFFFFF -> 0.
- EQ a=0x00000001, b=0x00000000 with EARLY_EXIT=1 -> done in cycle 5 (difference in the last slice), result=0.
- Start EQ at cycle 0; pulse start with new operands at cycle 2 -> ignored, result reflects first operands. Start again during the DONE cycle -> accepted, second done exactly N+1 cycles later.
- Flush in cycle 2 of an operation -> busy=0 in cycle 3, no done, result unchanged. Reset in cycle 3 of a second operation -> busy=done=result=0 next cycle. flush+start together -> state stays IDLE.
